snoop_bus_arbiter: RTL and testbench
====================================

Name: snoop_bus_arbiter

Overview:
Two-requester arbiter for the shared system bus between the two private cache controllers (A and B) of the snooping multiprocessor. It grants bus ownership round-robin and runs a snoop phase on the non-owner before every transfer. If the non-owner holds the line modified, it inserts a write-back (flush) phase so that cache updates memory before the owner transfers. All outputs are registered, and it sits between the cache controllers and the memory bus.

Parameters:
SNOOP_MAX, 8, cycles to wait for a snoop response before treating the line as clean (range 1..255)
XFER_MAX, 64, watchdog limit in cycles for FLUSH/XFER; used only with ARB_TIMEOUT_EN

Ports:
SCLK  input  1  system clock, rising edge
SRST  input  1  asynchronous reset, active-high
REQ_A  input  1  A requests bus; held high until GNT_A or abort
REQ_B  input  1  B requests bus; same rule
DONE_A  input  1  one-cycle pulse: A finished its transfer or flush
DONE_B  input  1  one-cycle pulse: B finished its transfer or flush
SVLD_A  input  1  A's snoop response valid (one-cycle pulse)
SVLD_B  input  1  B's snoop response valid (one-cycle pulse)
SHITM_A  input  1  with SVLD_A: A holds the snooped line modified
SHITM_B  input  1  with SVLD_B: B holds the snooped line modified
SNOOP_A  output  1  A must snoop B's address
SNOOP_B  output  1  B must snoop A's address
FLUSH_A  output  1  A must write back its modified line now
FLUSH_B  output  1  B must write back its modified line now
GNT_A  output  1  A owns the bus for its transfer
GNT_B  output  1  B owns the bus for its transfer
BUSY  output  1  high in every state except IDLE
TOUT  output  1  one-cycle watchdog-abort pulse

Behaviour:
- Reset (async, SRST=1): state=IDLE; all outputs 0; LAST=B, so A wins the first tie; snoop and watchdog counters cleared.
- Internal registers: OWNER (A/B), LAST (last granted owner), 8-bit snoop counter, watchdog counter. "Other" means the non-owner.
- IDLE: only REQ_A → OWNER=A; only REQ_B → OWNER=B; both → OWNER = requester not equal to LAST. Go to SNOOP. SNOOP_other rises on the cycle after REQ is sampled.
- SNOOP: SNOOP_other=1 and the counter increments each cycle.
  - SVLD_other with SHITM_other=1 → FLUSH.
  - SVLD_other with SHITM_other=0 → XFER.
  - Counter reaches SNOOP_MAX with no response → XFER (line treated as clean).
  - REQ_owner drops → IDLE with no grant; LAST is unchanged.
  - If SVLD and REQ drop occur together, the REQ drop wins.
- FLUSH: FLUSH_other=1 until DONE_other. Then go to XFER if REQ_owner is still high, else IDLE. The flush always completes, even if the owner's REQ drops.
- XFER: GNT_owner=1 and LAST=OWNER (updated on entry). DONE_owner → IDLE; GNT drops on the next edge.
- At most one of SNOOP_x/FLUSH_x/GNT_x is high at any time. GNT_A and GNT_B are never both high.
- DONE/SVLD/SHITM pulses outside their expected state or from the wrong side are ignored.
- Minimum turnaround: DONE → IDLE (1 cycle) → SNOOP. There is always at least one idle cycle between grants.
- Back-to-back: if both requesters stay high, grants alternate A, B, A, B.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined: a watchdog counts cycles in FLUSH and XFER and clears on state entry. If it reaches XFER_MAX without the expected DONE, the arbiter drops FLUSH/GNT, pulses TOUT for one cycle, and goes to IDLE. LAST=OWNER still applies if XFER was reached.
- Undefined: no watchdog logic; TOUT is tied to 0; FLUSH and XFER wait indefinitely for DONE.

Test Plan:
- Reset mid-XFER: GNT_A=1, assert SRST → all outputs 0 immediately (before the next edge); after release, REQ_A=REQ_B=1 → A wins.
- REQ_B only; SVLD_A=1 with SHITM_A=0 two cycles later → SNOOP_A for 2 cycles, GNT_B the next cycle; DONE_B → BUSY=0 the next cycle.
- REQ_A; SVLD_B=1 with SHITM_B=1 → FLUSH_B=1, GNT_A=0; DONE_B → GNT_A=1; DONE_A → IDLE.
- Both requesters held high for 4 transfers with clean snoops → grant order A, B, A, B; never both GNT high.
- REQ_A with no snoop response, SNOOP_MAX=8 → SNOOP_B high for exactly 8 cycles, then GNT_A; separately, REQ_A dropped during SNOOP → IDLE, no GNT.
- ARB_TIMEOUT_EN with XFER_MAX=64: GNT_A and no DONE_A → GNT_A falls after 64 cycles, TOUT=1 for one cycle; without the macro, GNT_A stays high and TOUT=0.

Source files
------------

// File: rtl/snoop_bus_arbiter.sv
// -----------------------------------------------------------------------------
// snoop_bus_arbiter
//
// Two-requester round-robin arbiter for the shared system bus between cache
// controllers A and B. Before every transfer the non-owner snoops the owner's
// address. If it holds the line modified, it first writes the line back
// (flush). The owner is then granted the bus. Every output is registered.
//
// Optional build macro: ARB_TIMEOUT_EN
//   defined   - a watchdog aborts FLUSH/XFER after XFER_MAX cycles without
//               DONE and pulses TOUT for one cycle
//   undefined - no watchdog; TOUT is tied low and FLUSH/XFER wait for DONE
// -----------------------------------------------------------------------------
module snoop_bus_arbiter #(
  parameter int SNOOP_MAX = 8,   // snoop response wait, 1..255 cycles
  parameter int XFER_MAX  = 64   // watchdog limit for FLUSH/XFER
) (
  input  logic SCLK,
  input  logic SRST,
  input  logic REQ_A,
  input  logic REQ_B,
  input  logic DONE_A,
  input  logic DONE_B,
  input  logic SVLD_A,
  input  logic SVLD_B,
  input  logic SHITM_A,
  input  logic SHITM_B,
  output logic SNOOP_A,
  output logic SNOOP_B,
  output logic FLUSH_A,
  output logic FLUSH_B,
  output logic GNT_A,
  output logic GNT_B,
  output logic BUSY,
  output logic TOUT
);

  // Elaboration-time parameter range checks.
  if (SNOOP_MAX < 1 || SNOOP_MAX > 255) begin : g_bad_snoop_max
    $error("snoop_bus_arbiter: SNOOP_MAX must be in 1..255");
  end
  if (XFER_MAX < 1) begin : g_bad_xfer_max
    $error("snoop_bus_arbiter: XFER_MAX must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_FLUSH,
    ST_XFER
  } state_t;

  typedef enum logic {
    SIDE_A,
    SIDE_B
  } side_t;

  // The full set of registered strobes, other than TOUT.
  typedef struct packed {
    logic snoop_a;
    logic snoop_b;
    logic flush_a;
    logic flush_b;
    logic gnt_a;
    logic gnt_b;
    logic busy;
  } out_t;

  localparam logic [7:0] SNOOP_LAST = 8'(SNOOP_MAX - 1);

  state_t state;
  side_t  owner;
  side_t  last;
  side_t  pick;
  logic [7:0] snoop_cnt;
  out_t   out_q;

  logic req_own;
  logic done_own;
  logic done_oth;
  logic svld_oth;
  logic shitm_oth;

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = ($clog2(XFER_MAX) < 1) ? 1 : $clog2(XFER_MAX);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(XFER_MAX - 1);
  logic [WD_W-1:0] wd_cnt;
  logic            tout_q;
`endif

  // Output pattern for a given state and owner. Only the non-owner snoops or
  // flushes and only the owner is granted, so at most one strobe per side is
  // ever high and the two grants are mutually exclusive by construction.
  function automatic out_t outs_for(state_t s, side_t o);
    out_t r;
    r = '0;
    case (s)
      ST_SNOOP: begin
        r.snoop_a = (o == SIDE_B);
        r.snoop_b = (o == SIDE_A);
      end
      ST_FLUSH: begin
        r.flush_a = (o == SIDE_B);
        r.flush_b = (o == SIDE_A);
      end
      ST_XFER: begin
        r.gnt_a = (o == SIDE_A);
        r.gnt_b = (o == SIDE_B);
      end
      default: ;
    endcase
    r.busy = (s != ST_IDLE);
    return r;
  endfunction

  // Steer the owner's and the non-owner's handshake inputs; pulses from the
  // wrong side never reach the FSM.
  always_comb begin
    req_own   = (owner == SIDE_A) ? REQ_A   : REQ_B;
    done_own  = (owner == SIDE_A) ? DONE_A  : DONE_B;
    done_oth  = (owner == SIDE_A) ? DONE_B  : DONE_A;
    svld_oth  = (owner == SIDE_A) ? SVLD_B  : SVLD_A;
    shitm_oth = (owner == SIDE_A) ? SHITM_B : SHITM_A;
  end

  // Round-robin pick in IDLE: a lone requester wins, a tie goes to the side
  // that was not granted last.
  always_comb begin
    pick = SIDE_A;
    if (REQ_A && REQ_B) begin
      pick = (last == SIDE_A) ? SIDE_B : SIDE_A;
    end else if (REQ_B) begin
      pick = SIDE_B;
    end
  end

  // Arbitration FSM. Outputs are loaded together with the state they belong
  // to, so every strobe is a flop and changes on the same edge as the state.
  // NOTE: sequential state uses non-blocking assignments only; a blocking
  // assignment here would let later statements see the new value and create
  // simulation/synthesis ordering mismatches.
  always_ff @(posedge SCLK or posedge SRST) begin
    if (SRST) begin
      state     <= ST_IDLE;
      owner     <= SIDE_A;
      last      <= SIDE_B;
      snoop_cnt <= '0;
      out_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      wd_cnt    <= '0;
      tout_q    <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      tout_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (REQ_A || REQ_B) begin
            state     <= ST_SNOOP;
            owner     <= pick;
            snoop_cnt <= '0;
            out_q     <= outs_for(ST_SNOOP, pick);
          end
        end

        ST_SNOOP: begin
          // A dropped request takes priority over a same-cycle snoop answer.
          if (!req_own) begin
            state <= ST_IDLE;
            out_q <= outs_for(ST_IDLE, owner);
          end else if (svld_oth && shitm_oth) begin
            state <= ST_FLUSH;
            out_q <= outs_for(ST_FLUSH, owner);
`ifdef ARB_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end else if (svld_oth || snoop_cnt == SNOOP_LAST) begin
            // Clean answer, or no answer in time: line treated as clean.
            state <= ST_XFER;
            last  <= owner;
            out_q <= outs_for(ST_XFER, owner);
`ifdef ARB_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end else begin
            snoop_cnt <= snoop_cnt + 8'd1;
          end
        end

        ST_FLUSH: begin
          // The write-back always finishes, whatever the owner's request does.
          if (done_oth) begin
            if (req_own) begin
              state <= ST_XFER;
              last  <= owner;
              out_q <= outs_for(ST_XFER, owner);
`ifdef ARB_TIMEOUT_EN
              wd_cnt <= '0;
`endif
            end else begin
              state <= ST_IDLE;
              out_q <= outs_for(ST_IDLE, owner);
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            state  <= ST_IDLE;
            out_q  <= outs_for(ST_IDLE, owner);
            tout_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end

        ST_XFER: begin
          if (done_own) begin
            state <= ST_IDLE;
            out_q <= outs_for(ST_IDLE, owner);
          end
`ifdef ARB_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            state  <= ST_IDLE;
            out_q  <= outs_for(ST_IDLE, owner);
            tout_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end

        default: begin
          state <= ST_IDLE;
          out_q <= '0;
        end
      endcase
    end
  end

  assign SNOOP_A = out_q.snoop_a;
  assign SNOOP_B = out_q.snoop_b;
  assign FLUSH_A = out_q.flush_a;
  assign FLUSH_B = out_q.flush_b;
  assign GNT_A   = out_q.gnt_a;
  assign GNT_B   = out_q.gnt_b;
  assign BUSY    = out_q.busy;

`ifdef ARB_TIMEOUT_EN
  assign TOUT = tout_q;
`else
  assign TOUT = 1'b0;
`endif

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_snoop_bus_arbiter
//
// Directed testbench for snoop_bus_arbiter (SNOOP_MAX=8, XFER_MAX=64). Inputs
// change 1 ns after a rising edge; outputs are sampled at the same point.
// Outputs are packed as {SNOOP_A,SNOOP_B,FLUSH_A,FLUSH_B,GNT_A,GNT_B,BUSY,TOUT}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_snoop_bus_arbiter;

  logic SCLK = 1'b0;
  logic SRST = 1'b1;
  logic REQ_A = 1'b0, REQ_B = 1'b0;
  logic DONE_A = 1'b0, DONE_B = 1'b0;
  logic SVLD_A = 1'b0, SVLD_B = 1'b0;
  logic SHITM_A = 1'b0, SHITM_B = 1'b0;
  logic SNOOP_A, SNOOP_B, FLUSH_A, FLUSH_B, GNT_A, GNT_B, BUSY, TOUT;

  int total = 0;
  int bad   = 0;

  // Expected output patterns.
  localparam logic [7:0] O_IDLE = 8'h00;
  localparam logic [7:0] O_SNA  = 8'h82;  // SNOOP_A + BUSY
  localparam logic [7:0] O_SNB  = 8'h42;  // SNOOP_B + BUSY
  localparam logic [7:0] O_FLA  = 8'h22;  // FLUSH_A + BUSY
  localparam logic [7:0] O_FLB  = 8'h12;  // FLUSH_B + BUSY
  localparam logic [7:0] O_GA   = 8'h0A;  // GNT_A + BUSY
  localparam logic [7:0] O_GB   = 8'h06;  // GNT_B + BUSY
  localparam logic [7:0] O_TOUT = 8'h01;  // TOUT only, back in IDLE

  snoop_bus_arbiter #(.SNOOP_MAX(8), .XFER_MAX(64)) dut (
    .SCLK(SCLK), .SRST(SRST),
    .REQ_A(REQ_A), .REQ_B(REQ_B),
    .DONE_A(DONE_A), .DONE_B(DONE_B),
    .SVLD_A(SVLD_A), .SVLD_B(SVLD_B),
    .SHITM_A(SHITM_A), .SHITM_B(SHITM_B),
    .SNOOP_A(SNOOP_A), .SNOOP_B(SNOOP_B),
    .FLUSH_A(FLUSH_A), .FLUSH_B(FLUSH_B),
    .GNT_A(GNT_A), .GNT_B(GNT_B),
    .BUSY(BUSY), .TOUT(TOUT)
  );

  always #5 SCLK = ~SCLK;

  function automatic logic [7:0] obs();
    return {SNOOP_A, SNOOP_B, FLUSH_A, FLUSH_B, GNT_A, GNT_B, BUSY, TOUT};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("reset_idle", obs(), O_IDLE);
    SRST = 1'b0;
    tick();
    check("idle_no_req", obs(), O_IDLE);

    // REQ_B only, clean snoop after two cycles
    REQ_B = 1'b1;
    tick();
    check("b_snoop1", obs(), O_SNA);
    tick();
    check("b_snoop2", obs(), O_SNA);
    SVLD_A = 1'b1; SHITM_A = 1'b0;
    tick();
    SVLD_A = 1'b0;
    check("b_grant", obs(), O_GB);
    REQ_B = 1'b0;
    tick();
    check("b_grant_hold", obs(), O_GB);
    DONE_B = 1'b1;
    tick();
    DONE_B = 1'b0;
    check("b_done_idle", obs(), O_IDLE);

    // REQ_A, modified hit in B -> flush then grant
    REQ_A = 1'b1;
    tick();
    check("a_snoop", obs(), O_SNB);
    SVLD_B = 1'b1; SHITM_B = 1'b1;
    tick();
    SVLD_B = 1'b0; SHITM_B = 1'b0;
    check("a_flush", obs(), O_FLB);
    DONE_A = 1'b1;  // wrong side during flush: ignored
    tick();
    DONE_A = 1'b0;
    check("a_flush_stray_done", obs(), O_FLB);
    DONE_B = 1'b1;
    tick();
    DONE_B = 1'b0;
    check("a_grant_after_flush", obs(), O_GA);
    REQ_A = 1'b0;
    DONE_A = 1'b1;
    tick();
    DONE_A = 1'b0;
    check("a_done_idle", obs(), O_IDLE);

    // Reset in the middle of a grant
    REQ_A = 1'b1;
    tick();
    check("rst_pre_snoop", obs(), O_SNB);
    SVLD_B = 1'b1;
    tick();
    SVLD_B = 1'b0;
    check("rst_pre_grant", obs(), O_GA);
    SRST = 1'b1;
    #1;
    check("rst_async_clear", obs(), O_IDLE);
    tick();
    SRST = 1'b0;

    // Back-to-back with both requesting: A, B, A, B
    REQ_A = 1'b1; REQ_B = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i % 2 == 0) begin
        check($sformatf("rr%0d_snoop", i), obs(), O_SNB);
        SVLD_B = 1'b1;
      end else begin
        check($sformatf("rr%0d_snoop", i), obs(), O_SNA);
        SVLD_A = 1'b1;
      end
      tick();
      SVLD_A = 1'b0; SVLD_B = 1'b0;
      if (i % 2 == 0) begin
        check($sformatf("rr%0d_grant", i), obs(), O_GA);
        DONE_A = 1'b1;
      end else begin
        check($sformatf("rr%0d_grant", i), obs(), O_GB);
        DONE_B = 1'b1;
      end
      tick();
      DONE_A = 1'b0; DONE_B = 1'b0;
      check($sformatf("rr%0d_idle", i), obs(), O_IDLE);
    end
    REQ_A = 1'b0; REQ_B = 1'b0;
    tick();
    check("rr_quiet", obs(), O_IDLE);

    // No snoop response: SNOOP_B for exactly 8 cycles, then grant
    REQ_A = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("snto_snoop%0d", i), obs(), O_SNB);
    end
    tick();
    check("snto_grant", obs(), O_GA);
    REQ_A = 1'b0;
    DONE_A = 1'b1;
    tick();
    DONE_A = 1'b0;
    check("snto_idle", obs(), O_IDLE);

    // REQ dropped during snoop, together with a snoop answer -> no grant
    REQ_A = 1'b1;
    tick();
    check("abort_snoop", obs(), O_SNB);
    REQ_A = 1'b0; SVLD_B = 1'b1;
    tick();
    SVLD_B = 1'b0;
    check("abort_idle", obs(), O_IDLE);
    tick();
    check("abort_no_grant", obs(), O_IDLE);

    // LAST unchanged by the abort (still A) -> tie goes to B
    REQ_A = 1'b1; REQ_B = 1'b1;
    tick();
    check("last_kept_b_wins", obs(), O_SNA);
    REQ_A = 1'b0; REQ_B = 1'b0;
    tick();
    check("last_kept_abort", obs(), O_IDLE);

    // Flush completes even though the owner's request dropped
    REQ_B = 1'b1;
    tick();
    check("fl_drop_snoop", obs(), O_SNA);
    SVLD_A = 1'b1; SHITM_A = 1'b1;
    tick();
    SVLD_A = 1'b0; SHITM_A = 1'b0;
    check("fl_drop_flush", obs(), O_FLA);
    REQ_B = 1'b0;
    tick();
    check("fl_drop_flush_hold", obs(), O_FLA);
    DONE_A = 1'b1;
    tick();
    DONE_A = 1'b0;
    check("fl_drop_idle", obs(), O_IDLE);

    // Grant with no DONE: watchdog behaviour depends on the build
    REQ_A = 1'b1;
    tick();
    check("wd_snoop", obs(), O_SNB);
    SVLD_B = 1'b1;
    tick();
    SVLD_B = 1'b0;
    REQ_A = 1'b0;
    check("wd_grant0", obs(), O_GA);
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i < 64; i++) begin
      tick();
      check($sformatf("wd_grant%0d", i), obs(), O_GA);
    end
    tick();
    check("wd_tout_pulse", obs(), O_TOUT);
    tick();
    check("wd_tout_end", obs(), O_IDLE);
`else
    for (int i = 1; i < 100; i++) begin
      tick();
      if (i % 20 == 0) check($sformatf("wd_grant%0d", i), obs(), O_GA);
    end
    DONE_A = 1'b1;
    tick();
    DONE_A = 1'b0;
    check("wd_none_idle", obs(), O_IDLE);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
